// File: rtl/cpu_mul_seq.sv
// Sequenced 32x32->64 multiplier: four 16x16 partial products through one
// pipelined unsigned multiplier, sign applied to the accumulated magnitude.
module cpu_mul_seq #(
  parameter int MUL_PIPE   = 1,
  parameter int EARLY_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        sign1,
  input  logic        sign2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  // DRAIN covers the multiplier pipe plus the edge that accumulates step 3.
  localparam logic [1:0] DRAIN_LAST = 2'(MUL_PIPE);

  state_e                    state_q;
  logic                      req_ready_q;
  logic                      rsp_valid_q;
  logic                      neg_q;
  logic [63:0]               result_q;
  logic [63:0]               acc_q;
  logic [31:0]               mag_a_q;
  logic [31:0]               mag_b_q;
  logic [1:0]                step_q;
  logic [1:0]                drain_q;
  logic [MUL_PIPE-1:0][31:0] prod_q;
  logic [MUL_PIPE-1:0][1:0]  tag_q;
  logic [MUL_PIPE-1:0]       vld_q;

  logic [15:0] mul_a_d;
  logic [15:0] mul_b_d;
  logic [63:0] pp_d;
  logic [63:0] acc_d;
  logic        accept_d;
  logic        zero_d;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic s);
    magnitude = (s && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Operand selection per step and weighting of the product leaving the pipe.
  always_comb begin
    accept_d = req_valid && req_ready_q && (state_q == IDLE);
    zero_d   = (EARLY_ZERO != 0) && ((src1 == 32'd0) || (src2 == 32'd0));
    case (step_q)
      2'd0: begin mul_a_d = mag_a_q[15:0];  mul_b_d = mag_b_q[15:0];  end
      2'd1: begin mul_a_d = mag_a_q[15:0];  mul_b_d = mag_b_q[31:16]; end
      2'd2: begin mul_a_d = mag_a_q[31:16]; mul_b_d = mag_b_q[15:0];  end
      2'd3: begin mul_a_d = mag_a_q[31:16]; mul_b_d = mag_b_q[31:16]; end
      default: begin mul_a_d = 16'd0; mul_b_d = 16'd0; end
    endcase
    case (tag_q[MUL_PIPE-1])
      2'd0:       pp_d = {32'd0, prod_q[MUL_PIPE-1]};
      2'd1, 2'd2: pp_d = {16'd0, prod_q[MUL_PIPE-1], 16'd0};
      2'd3:       pp_d = {prod_q[MUL_PIPE-1], 32'd0};
      default:    pp_d = 64'd0;
    endcase
    if (vld_q[MUL_PIPE-1]) begin
      acc_d = acc_q + pp_d;
    end else begin
      acc_d = acc_q;
    end
  end

  // 16x16 multiplier pipeline with the step tag travelling alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      tag_q  <= '0;
      vld_q  <= '0;
    end else begin
      prod_q[0] <= {16'd0, mul_a_d} * {16'd0, mul_b_d};
      tag_q[0]  <= step_q;
      vld_q[0]  <= (state_q == ISSUE);
      for (int i = 1; i < MUL_PIPE; i++) begin
        prod_q[i] <= prod_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  // Sequencer FSM, accumulator and registered handshake/result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      neg_q       <= 1'b0;
      result_q    <= 64'd0;
      acc_q       <= 64'd0;
      mag_a_q     <= 32'd0;
      mag_b_q     <= 32'd0;
      step_q      <= 2'd0;
      drain_q     <= 2'd0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept_d) begin
            req_ready_q <= 1'b0;
            mag_a_q     <= magnitude(src1, sign1);
            mag_b_q     <= magnitude(src2, sign2);
            neg_q       <= (sign1 & src1[31]) ^ (sign2 & src2[31]);
            acc_q       <= 64'd0;
            step_q      <= 2'd0;
            if (zero_d) begin
              result_q    <= 64'd0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            drain_q <= 2'd0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            result_q    <= neg_q ? (~acc_q + 64'd1) : acc_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_cpu_mul_seq.sv
// Directed bench for cpu_mul_seq: three instances cover MUL_PIPE=1/2 and
// EARLY_ZERO on/off; expected products are hand-computed constants.
module tb_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [2:0]  sign1;
  logic [2:0]  sign2;
  logic [31:0] src1 [3];
  logic [31:0] src2 [3];
  logic [63:0] result [3];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  // dut0: MUL_PIPE=1 no bypass, dut1: MUL_PIPE=1 bypass, dut2: MUL_PIPE=2 bypass
  cpu_mul_seq #(.MUL_PIPE(1), .EARLY_ZERO(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .src1(src1[0]), .src2(src2[0]), .sign1(sign1[0]), .sign2(sign2[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .result(result[0]));
  cpu_mul_seq #(.MUL_PIPE(1), .EARLY_ZERO(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .src1(src1[1]), .src2(src2[1]), .sign1(sign1[1]), .sign2(sign2[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .result(result[1]));
  cpu_mul_seq #(.MUL_PIPE(2), .EARLY_ZERO(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .src1(src1[2]), .src2(src2[2]), .sign1(sign1[2]), .sign2(sign2[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .result(result[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s1, input logic s2);
    logic signed [65:0] ea;
    logic signed [65:0] eb;
    logic signed [65:0] p;
    ea = s1 ? $signed({{34{a[31]}}, a}) : $signed({34'd0, a});
    eb = s2 ? $signed({{34{b[31]}}, b}) : $signed({34'd0, b});
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Present a request and return just after its accept edge.
  task automatic start_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic s1, input logic s2, input string tag);
    int n;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk1({tag, "/ready"}, req_ready[d], 1'b1);
    req_valid[d] = 1'b1; src1[d] = a; src2[d] = b; sign1[d] = s1; sign2[d] = s2;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    src1[d] = $urandom; src2[d] = $urandom; sign1[d] = ~s1; sign2[d] = ~s2;
    chk1({tag, "/taken"}, req_ready[d], 1'b0);
  endtask

  // Count edges after accept until rsp_valid, watching req_ready stays low.
  task automatic wait_rsp(input int d, input logic [63:0] exp, input int lat, input string tag);
    int   n;
    logic rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      if (req_ready[d] !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk); #1; n++;
    end
    chk({tag, "/latency"}, 64'(n), 64'(lat));
    chk1({tag, "/busy"}, rdy_seen | req_ready[d], 1'b0);
    chk({tag, "/result"}, result[d], exp);
  endtask

  task automatic finish_rsp(input int d, input logic [63:0] exp, input string tag);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk1({tag, "/rsp_drop"}, rsp_valid[d], 1'b0);
    chk1({tag, "/ready_back"}, req_ready[d], 1'b1);
    chk({tag, "/result_kept"}, result[d], exp);
  endtask

  task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic s1, input logic s2, input logic [63:0] exp,
                       input int lat, input string tag);
    start_op(d, a, b, s1, s2, tag);
    wait_rsp(d, exp, lat, tag);
    finish_rsp(d, exp, tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs1;
    logic        rs2;

    reset = 1'b1;
    req_valid = 3'd0; rsp_ready = 3'd0; sign1 = 3'd0; sign2 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      src1[i] = 32'd0; src2[i] = 32'd0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("rst%0d/req_ready", i), req_ready[i], 1'b0);
      chk1($sformatf("rst%0d/rsp_valid", i), rsp_valid[i], 1'b0);
      chk($sformatf("rst%0d/result", i), result[i], 64'd0);
    end
    #10 reset = 1'b0;
    #1;
    chk1("rel/ready_before_edge", req_ready[1], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk1($sformatf("rel%0d/ready_up", i), req_ready[i], 1'b1);

    // MUL_PIPE = 1, bypass enabled
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, 6, "umax");
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001, 6, "m1xm1");
    do_op(1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h4000000000000000, 6, "min_sq_s");
    do_op(1, 32'h80000000, 32'h00000002, 1'b1, 1'b0, 64'hFFFFFFFF00000000, 6, "min_x2");
    do_op(1, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 64'h4000000000000000, 6, "min_sq_u");
    do_op(1, 32'h80000000, 32'h00000002, 1'b0, 1'b0, 64'h0000000100000000, 6, "no_sext");
    do_op(1, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 64'h0000000000000000, 0, "ezero");

    // MUL_PIPE = 1, bypass disabled
    do_op(0, 32'h00000001, 32'hDEADBEEF, 1'b0, 1'b0, 64'h00000000DEADBEEF, 6, "one");
    do_op(0, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 64'h0000000000000000, 6, "nozero");

    // Backpressure: response held, new request pulses must be ignored
    start_op(1, 32'd7, 32'd9, 1'b0, 1'b0, "bp");
    wait_rsp(1, 64'd63, 6, "bp");
    for (int k = 0; k < 10; k++) begin
      req_valid[1] = k[0];
      src1[1] = 32'h11111111; src2[1] = 32'h00000002; sign1[1] = 1'b0; sign2[1] = 1'b0;
      @(posedge clk); #1;
      chk1("bp/hold_valid", rsp_valid[1], 1'b1);
      chk("bp/hold_result", result[1], 64'd63);
      chk1("bp/hold_ready", req_ready[1], 1'b0);
    end
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[1] = 1'b0;
    chk1("bp/hs_valid", rsp_valid[1], 1'b0);
    chk1("bp/hs_ready", req_ready[1], 1'b1);
    chk("bp/hs_result", result[1], 64'd63);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk1("bp/next_taken", req_ready[1], 1'b0);
    wait_rsp(1, 64'h0000000022222222, 6, "bp2");
    finish_rsp(1, 64'h0000000022222222, "bp2");

    // Reset during ISSUE step 2 aborts the operation
    start_op(1, 32'h00010000, 32'h00010000, 1'b0, 1'b0, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk1("abort/rsp_valid", rsp_valid[1], 1'b0);
    chk("abort/result", result[1], 64'd0);
    chk1("abort/req_ready", req_ready[1], 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk1("abort/ready_up", req_ready[1], 1'b1);
    chk1("abort/no_rsp", rsp_valid[1], 1'b0);
    do_op(1, 32'd3, 32'd5, 1'b0, 1'b0, 64'h000000000000000F, 6, "post_rst");

    // MUL_PIPE = 2
    do_op(2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'h0B00EA4E242D2080, 7, "p2_ref");
    do_op(2, 32'hFFFFFFFD, 32'h00000005, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1, 7, "p2_neg");
    do_op(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF00000001, 7, "p2_mix");
    do_op(2, 32'hABCDEF01, 32'h00000000, 1'b1, 1'b1, 64'h0000000000000000, 0, "p2_zero");
    for (int k = 0; k < 6; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      rs1 = 1'($urandom_range(0, 1));
      rs2 = 1'($urandom_range(0, 1));
      if (ra == 32'd0) ra = 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      do_op(2, ra, rb, rs1, rs2, ref_mul(ra, rb, rs1, rs2), 7, $sformatf("p2_rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
